// File: rtl/register_writeback_queue_pkg.sv
// ---------------------------------------------------------------------------
// register_writeback_queue_pkg
//
// Shared definitions for the register write-back queue:
//   - WB_OP_WRITE / WB_OP_INCR : values of the two op bits {write, incr}
//     stored in the low end of every queue entry.
//   - wb_index_width()         : width of the target register index.
//   - wb_entry_width()         : width of one packed queue entry,
//                                {reg, data, increment, write, incr}.
// ---------------------------------------------------------------------------
package register_writeback_queue_pkg;

    // Op field is {write, incr}.
    localparam logic [1:0] WB_OP_WRITE = 2'b10;
    localparam logic [1:0] WB_OP_INCR  = 2'b01;

    function automatic int wb_index_width(input int regs);
        return $clog2(regs);
    endfunction

    function automatic int wb_entry_width(input int regs, input int width);
        return $clog2(regs) + 2 * width + 2;
    endfunction

endpackage

// File: rtl/register_writeback_queue_fifo_mem.sv
// ---------------------------------------------------------------------------
// writeback_fifo_mem
//
// DEPTH x EW storage array for the write-back queue. One synchronous write
// port and one asynchronous read port that presents the head entry. The
// array holds no reset: validity of each slot is tracked by the pointers and
// count in the parent.
//
// Ports:
//   clock        in   write clock
//   write_en     in   store write_entry at write_addr on the rising edge
//   write_addr   in   slot to write
//   write_entry  in   packed entry to store
//   read_addr    in   slot to read (head of queue)
//   read_entry   out  contents of read_addr, combinational
// ---------------------------------------------------------------------------
module writeback_fifo_mem #(
    parameter int EW    = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  logic [EW-1:0]            write_entry,
    input  logic [$clog2(DEPTH)-1:0] read_addr,
    output logic [EW-1:0]            read_entry
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_entry;
        end
    end

    assign read_entry = mem[read_addr];

endmodule

// File: rtl/register_writeback_queue.sv
// ---------------------------------------------------------------------------
// register_writeback_queue
//
// Small FIFO in front of the register bank. Buffers write-back / increment
// requests from the execute stage and drains at most one per cycle into the
// bank's shared data_in / increment buses and one-hot per-register enables.
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready.
// in_ready depends only on the occupancy (count != DEPTH), never on in_valid,
// hold or a same-cycle pop. A transferred request with neither in_write nor
// in_incr set is consumed and dropped.
//
// Draining: when the queue is non-empty and hold is low, the head entry's
// enable is asserted and the bank captures on the same edge that advances
// the read pointer. Write wins over increment for a given entry.
//
// Optional build macro UCISC_WB_BYPASS_EN: when defined, a qualifying request
// accepted while the queue is empty and hold is low drives the outputs in the
// same cycle and is not enqueued. Undefined (default): every request is
// enqueued and reaches the bank one edge later at the earliest.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   in_valid / in_ready     request handshake
//   in_reg, in_data,
//   in_increment,
//   in_write, in_incr       request payload
//   hold                    stall draining (queue still accepts)
//   out_data, out_increment shared buses to the bank
//   out_write_enable        one-hot write enable per register
//   out_increment_enable    one-hot increment enable per register
//   count                   occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module register_writeback_queue
    import register_writeback_queue_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int REGS  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(REGS)-1:0]  in_reg,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [WIDTH-1:0]         in_increment,
    input  logic                     in_write,
    input  logic                     in_incr,
    input  logic                     hold,
    output logic [WIDTH-1:0]         out_data,
    output logic [WIDTH-1:0]         out_increment,
    output logic [REGS-1:0]          out_write_enable,
    output logic [REGS-1:0]          out_increment_enable,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = wb_index_width(REGS);
    localparam int EW = wb_entry_width(REGS, WIDTH);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [EW-1:0] head;
    logic [EW-1:0] new_entry;

    logic accept;
    logic push;
    logic pop;
    logic bypass;
    logic enq;
    logic empty;

    assign empty     = (count_q == '0);
    assign in_ready  = (count_q != (AW + 1)'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign push      = accept & (in_write | in_incr);
    assign pop       = ~empty & ~hold;
    assign new_entry = {in_reg, in_data, in_increment, in_write, in_incr};

`ifdef UCISC_WB_BYPASS_EN
    // Only possible when empty, so it never collides with a pop.
    assign bypass = empty & ~hold & push;
`else
    assign bypass = 1'b0;
`endif

    assign enq   = push & ~bypass;
    assign count = count_q;

    writeback_fifo_mem #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock       (clock),
        .write_en    (enq),
        .write_addr  (wr_ptr),
        .write_entry (new_entry),
        .read_addr   (rd_ptr),
        .read_entry  (head)
    );

    // Output source: the bypassed request, else the head entry.
    logic [EW-1:0]    src;
    logic             src_drive;
    logic             src_shown;
    logic [IW-1:0]    src_reg;
    logic [1:0]       src_op;

    always_comb begin
        src       = head;
        src_drive = pop;
        src_shown = ~empty;
        if (bypass) begin
            src       = new_entry;
            src_drive = 1'b1;
            src_shown = 1'b1;
        end
    end

    assign src_reg = src[EW-1 -: IW];
    assign src_op  = src[1:0];

    always_comb begin
        out_data             = '0;
        out_increment        = '0;
        out_write_enable     = '0;
        out_increment_enable = '0;
        if (src_shown) begin
            out_data      = src[2*WIDTH+1 -: WIDTH];
            out_increment = src[WIDTH+1 -: WIDTH];
        end
        if (src_drive) begin
            if ((src_op & WB_OP_WRITE) != 2'b00) begin
                out_write_enable[src_reg] = 1'b1;
            end else if (src_op == WB_OP_INCR) begin
                out_increment_enable[src_reg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_register_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_register_writeback_queue
//
// Self-checking bench for register_writeback_queue. A request-level model
// (a queue of pending requests) predicts in_ready, count and the bank-side
// outputs every cycle. Honours UCISC_WB_BYPASS_EN if defined for the build.
// ---------------------------------------------------------------------------
module tb_register_writeback_queue;

    localparam int WIDTH = 16;
    localparam int REGS  = 4;
    localparam int DEPTH = 4;

`ifdef UCISC_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_reg = '0;
    logic [WIDTH-1:0]  in_data = '0;
    logic [WIDTH-1:0]  in_increment = '0;
    logic              in_write = 1'b0;
    logic              in_incr = 1'b0;
    logic              hold = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic [WIDTH-1:0]  out_increment;
    logic [REGS-1:0]   out_write_enable;
    logic [REGS-1:0]   out_increment_enable;
    logic [2:0]        count;

    register_writeback_queue #(
        .WIDTH (WIDTH),
        .REGS  (REGS),
        .DEPTH (DEPTH)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_reg               (in_reg),
        .in_data              (in_data),
        .in_increment         (in_increment),
        .in_write             (in_write),
        .in_incr              (in_incr),
        .hold                 (hold),
        .out_data             (out_data),
        .out_increment        (out_increment),
        .out_write_enable     (out_write_enable),
        .out_increment_enable (out_increment_enable),
        .count                (count)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int unsigned r;
        int unsigned d;
        int unsigned inc;
        bit          w;
        bit          i;
    } req_t;

    req_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every observable output against the model for the current
    // (pre-edge) state and the inputs now being driven.
    task automatic check_outputs(input string tag);
        int unsigned sz;
        bit          byp;
        bit          pop;
        req_t        src;
        bit          drive;
        bit          shown;
        int unsigned exp_we;
        int unsigned exp_ie;
        sz    = exp_q.size();
        byp   = BYPASS && sz == 0 && !hold && in_valid && (in_write || in_incr);
        pop   = sz != 0 && !hold;
        drive = 1'b0;
        shown = 1'b0;
        src   = '{r: 0, d: 0, inc: 0, w: 0, i: 0};
        if (byp) begin
            src   = '{r: in_reg, d: in_data, inc: in_increment, w: in_write, i: in_incr};
            drive = 1'b1;
            shown = 1'b1;
        end else if (sz != 0) begin
            src   = exp_q[0];
            drive = pop;
            shown = 1'b1;
        end
        exp_we = (drive && src.w) ? (1 << src.r) : 0;
        exp_ie = (drive && src.i && !src.w) ? (1 << src.r) : 0;
        check_val({tag, ".in_ready"}, 64'(in_ready), 64'(sz != DEPTH));
        check_val({tag, ".count"}, 64'(count), 64'(sz));
        check_val({tag, ".out_data"}, 64'(out_data), shown ? 64'(src.d) : 64'd0);
        check_val({tag, ".out_increment"}, 64'(out_increment), shown ? 64'(src.inc) : 64'd0);
        check_val({tag, ".out_write_enable"}, 64'(out_write_enable), 64'(exp_we));
        check_val({tag, ".out_increment_enable"}, 64'(out_increment_enable), 64'(exp_ie));
    endtask

    // ---------------- driver ----------------
    // One cycle: drive at the falling edge, check 1 ns later, advance the
    // model on the following rising edge. acc reports the handshake.
    task automatic drive_cycle(input string tag, input bit v, input int unsigned r,
                               input int unsigned d, input int unsigned inc,
                               input bit w, input bit i, input bit h, output bit acc);
        int unsigned sz;
        bit          byp;
        bit          pop;
        @(negedge clock);
        in_valid     = v;
        in_reg       = 2'(r);
        in_data      = WIDTH'(d);
        in_increment = WIDTH'(inc);
        in_write     = w;
        in_incr      = i;
        hold         = h;
        #1;
        check_outputs(tag);
        sz  = exp_q.size();
        acc = v && (sz != DEPTH);
        byp = BYPASS && sz == 0 && !h && acc && (w || i);
        pop = sz != 0 && !h;
        @(posedge clock);
        if (pop) void'(exp_q.pop_front());
        if (acc && (w || i) && !byp)
            exp_q.push_back('{r: r & 3, d: d & 16'hFFFF, inc: inc & 16'hFFFF, w: w, i: i});
    endtask

    task automatic idle(input string tag, input int n);
        bit acc;
        for (int k = 0; k < n; k++) drive_cycle(tag, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        bit got_in;

        // Power-on reset.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("reset.count", 64'(count), 64'd0);
        check_val("reset.in_ready", 64'(in_ready), 64'd1);
        check_val("reset.out_write_enable", 64'(out_write_enable), 64'd0);
        check_val("reset.out_increment_enable", 64'(out_increment_enable), 64'd0);
        check_val("reset.out_data", 64'(out_data), 64'd0);
        reset = 1'b0;

        // Single write to r2.
        drive_cycle("wr_r2", 1, 2, 16'h1234, 0, 1, 0, 0, acc);
        idle("wr_r2_drain", 2);

        // Write and increment both set: write wins.
        drive_cycle("wr_incr_r1", 1, 1, 16'h00FF, 16'h0002, 1, 1, 0, acc);
        idle("wr_incr_drain", 2);

        // Null request: consumed, not enqueued.
        drive_cycle("null_req", 1, 3, 16'hBEEF, 16'h0001, 0, 0, 0, acc);
        check_val("null_req.accepted", 64'(acc), 64'd1);
        idle("null_drain", 1);

        // Increment r3 by -1 (bypass shows it in the same cycle if built in).
        drive_cycle("incr_r3", 1, 3, 0, 16'hFFFF, 0, 1, 0, acc);
        idle("incr_drain", 2);

        // Fill under hold, fifth request is refused, then drains in order.
        for (int k = 0; k < DEPTH; k++)
            drive_cycle("hold_fill", 1, k, 16'h1000 + k, k, 1, 0, 1, acc);
        @(negedge clock);
        hold = 1'b1; in_valid = 1'b0;
        #1;
        check_val("hold_full.count", 64'(count), 64'd4);
        check_val("hold_full.in_ready", 64'(in_ready), 64'd0);
        drive_cycle("hold_fifth", 1, 1, 16'h5555, 16'h0003, 0, 1, 1, acc);
        check_val("hold_fifth.refused", 64'(acc), 64'd0);
        got_in = 1'b0;
        for (int k = 0; k < 10 && !got_in; k++) begin
            drive_cycle("release", 1, 1, 16'h5555, 16'h0003, 0, 1, 0, acc);
            got_in = acc;
        end
        check_val("release.fifth_accepted", 64'(got_in), 64'd1);
        idle("release_drain", 6);

        // Reset with three entries queued and draining enabled.
        for (int k = 0; k < 3; k++)
            drive_cycle("pre_reset", 1, k, 16'hA000 + k, 0, 0, 1, 1, acc);
        @(negedge clock);
        in_valid = 1'b0; hold = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check_val("mid_reset.count", 64'(count), 64'd0);
        check_val("mid_reset.in_ready", 64'(in_ready), 64'd1);
        check_val("mid_reset.out_write_enable", 64'(out_write_enable), 64'd0);
        check_val("mid_reset.out_increment_enable", 64'(out_increment_enable), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        idle("post_reset", 2);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive_cycle("rand",
                        $urandom_range(0, 3) != 0,
                        $urandom_range(0, REGS - 1),
                        $urandom_range(0, 16'hFFFF),
                        $urandom_range(0, 16'hFFFF),
                        1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)),
                        $urandom_range(0, 3) == 0,
                        acc);
        end
        idle("final_drain", 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Time bound on the whole run.
    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
